// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/avg pooling over a raster-order valid/ready pixel stream.
// One line buffer holds the even row; the odd row completes each window in flight.
module pool2x2_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FM_W   = 6,
  parameter int unsigned FM_H   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);

  if ((FM_W < 2) || (FM_W % 2 != 0)) begin : gen_bad_fm_w
    $error("pool2x2_stream: FM_W must be even and >= 2");
  end
  if ((FM_H < 2) || (FM_H % 2 != 0)) begin : gen_bad_fm_h
    $error("pool2x2_stream: FM_H must be even and >= 2");
  end

  localparam int unsigned CW = $clog2(FM_W);
  localparam int unsigned RW = $clog2(FM_H);
  localparam logic [CW-1:0] ColLast = CW'(FM_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(FM_H - 1);

  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic              mode_q;
  logic [DATA_W-1:0] line_buf [FM_W];
  logic [DATA_W-1:0] left_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;

  logic              accept;
  logic              win_done;
  logic              frame_end;
  logic [CW-1:0]     col_even;
  logic [DATA_W-1:0] win_a, win_b, win_c, win_d;
  logic [DATA_W+1:0] sum;
  logic [DATA_W+1:0] avg_full;
  logic [DATA_W-1:0] max_ab, max_cd, max_all;
  logic [DATA_W-1:0] result;

  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign win_done   = accept && row_q[0] && col_q[0];
  assign frame_end  = (row_q == RowLast) && (col_q == ColLast);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = out_valid_q && out_ready && out_last_q;

  // Window only completes on odd columns, so clearing bit 0 gives col-1.
  assign col_even = col_q & ~CW'(1);
  assign win_a    = line_buf[col_even];
  assign win_b    = line_buf[col_q];
  assign win_c    = left_q;
  assign win_d    = in_data;

  assign sum = {{2{win_a[DATA_W-1]}}, win_a} + {{2{win_b[DATA_W-1]}}, win_b}
             + {{2{win_c[DATA_W-1]}}, win_c} + {{2{win_d[DATA_W-1]}}, win_d};
  assign avg_full = $signed(sum) >>> 2;

  assign max_ab  = ($signed(win_a) > $signed(win_b)) ? win_a : win_b;
  assign max_cd  = ($signed(win_c) > $signed(win_d)) ? win_c : win_d;
  assign max_all = ($signed(max_ab) > $signed(max_cd)) ? max_ab : max_cd;
  assign result  = mode_q ? max_all : avg_full[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if ((row_q == '0) && (col_q == '0)) begin
          mode_q <= mode;
        end
      end
      if (win_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        out_last_q  <= frame_end;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Pure datapath storage; contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (accept && !row_q[0]) begin
      line_buf[col_q] <= in_data;
    end
    if (accept && row_q[0] && !col_q[0]) begin
      left_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: driver pushes expected pooled results,
// monitor pops and compares on every output handshake.
module tb_pool2x2_stream;

  localparam int W = 6;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        frame_done;

  logic        rst2;
  logic        mode2;
  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] in_data2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_last2;
  logic        frame_done2;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  int   pix[N];

  always #5 clk = ~clk;

  pool2x2_stream #(.DATA_W(32), .FM_W(W), .FM_H(H)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_done(frame_done)
  );

  pool2x2_stream #(.DATA_W(32), .FM_W(2), .FM_H(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst2),
    .mode      (mode2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (1'b1),
    .out_data  (out_data2),
    .out_last  (out_last2),
    .frame_done(frame_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Reference pooling straight from the window definition.
  function automatic logic [31:0] pool_ref(input int a, input int b, input int c, input int d,
                                           input bit m);
    longint s;
    int     mx;
    if (m) begin
      mx = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      if (d > mx) mx = d;
      return mx;
    end
    s = longint'(a) + longint'(b) + longint'(c) + longint'(d);
    s = (s - (((s % 4) + 4) % 4)) / 4;
    return s[31:0];
  endfunction

  task automatic drive_frame(input int kind, input bit m, input int toggle_at, input bit gaps,
                             input bit rnd_ready, input bit stall, input int rst_at);
    int  p = 0;
    int  stall_left = 0;
    bit  stalled_once = 0;
    int  guard = 0;
    int  cur;
    int  r, c;
    exp_t e;
    cur = 0;
    while (p < N) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        tests++;
        failed++;
        $display("FAIL frame_timeout: got %0d pixels accepted expected %0d", p, N);
        return;
      end
      if (p == rst_at) begin
        check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        return;
      end
      case (kind)
        0:       cur = p;
        1:       cur = int'($urandom);
        default: cur = int'($urandom_range(0, 15)) - 8;
      endcase
      mode     = (toggle_at >= 0 && p >= toggle_at) ? !m : m;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = cur;
      if (stall && !stalled_once && out_valid) begin
        stall_left   = 5;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (!out_ready && out_valid) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (!rnd_ready && !stall) check("in_ready_high", {31'd0, in_ready}, 32'd1);
      if (in_valid && in_ready) begin
        pix[p] = cur;
        r = p / W;
        c = p % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e.data = pool_ref(pix[(r - 1) * W + c - 1], pix[(r - 1) * W + c],
                            pix[r * W + c - 1], pix[p], m);
          e.last = (p == N - 1);
          sb.push_back(e);
        end
        p++;
      end
    end
  endtask

  // Output monitor.
  initial begin
    bit          held = 0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 0;
        continue;
      end
      if (held) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, hd);
        check("hold_last", {31'd0, out_last}, {31'd0, hl});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_out: got data %0d with no expected result", $signed(out_data));
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
          check("frame_done", {31'd0, frame_done}, {31'd0, e.last});
        end
        held = 0;
      end else begin
        check("frame_done_idle", {31'd0, frame_done}, 32'd0);
        held = out_valid;
        hd   = out_data;
        hl   = out_last;
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    rst2 = 1'b1;
    mode = 1'b0;
    mode2 = 1'b0;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    in_data = '0;
    in_data2 = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);

    drive_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);  // ramp, avg
    drive_frame(0, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1);  // ramp, max
    drive_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);  // first-result stall
    drive_frame(0, 1'b0, 10, 1'b0, 1'b0, 1'b0, -1);  // mode flips mid-frame
    drive_frame(0, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    drive_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 20);  // reset mid-frame
    drive_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    for (int f = 0; f < 8; f++) begin
      drive_frame(1 + (f % 2), 1'($urandom_range(0, 1)), -1, 1'b1, 1'b1, 1'b0, -1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", sb.size(), 32'd0);

    // Negative rounding on a 2x2 frame, avg then max.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        mode2 = 1'(m);
        in_valid2 = 1'b1;
        in_data2 = -(i + 1);
        #1;
        check("tiny_in_ready", {31'd0, in_ready2}, 32'd1);
      end
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      check("tiny_valid", {31'd0, out_valid2}, 32'd1);
      check("tiny_data", out_data2, (m == 0) ? -32'sd3 : -32'sd1);
      check("tiny_last", {31'd0, out_last2}, 32'd1);
      check("tiny_frame_done", {31'd0, frame_done2}, 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pool2x2_stream.md
Name: pool2x2_stream

Overview:
- Parametrised 2x2, stride-2 pooling stage for the CNN core. Sits between a convolution/activation output stream and the next layer.
- Consumes one signed pixel per beat in raster order over a valid/ready handshake. Emits the pooled feature map over a second valid/ready stream.
- Unlike the fixed 6x6 average-only pool, it has parametrised geometry and data width, a runtime max/avg mode, a single-row line buffer, output backpressure, and end-of-frame signalling.

Parameters:
- DATA_W, 32: signed pixel width, input and output.
- FM_W, 6: input feature-map width in pixels. Must be even and >= 2; elaboration error otherwise.
- FM_H, 6: input feature-map height in pixels. Must be even and >= 2; elaboration error otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = average pool, 1 = max pool; sampled on the first accepted pixel of a frame
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  DATA_W  signed input pixel
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  signed pooled result
- out_last  out  1  qualifies out_data as the final pooled pixel of the frame
- frame_done  out  1  one-cycle pulse when the final pooled pixel is accepted downstream

Behaviour:
- Reset: in_ready=1, out_valid=0, out_data=0, out_last=0, frame_done=0. Row/col counters=0. Latched mode=0. Line-buffer contents are don't-care.
- Reset mid-frame: the partial frame is discarded and any pending output is dropped. The next accepted pixel is treated as pixel (0,0).
- Input transfer occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, so it is combinational from out_ready. No combinational path from in_valid to out_valid.
- Counters: col runs 0..FM_W-1, row 0..FM_H-1, advancing only on an input transfer. col wraps to 0 and row increments at end of row. After (FM_H-1, FM_W-1) both wrap to 0, and the next pixel starts a new frame.
- Mode latch: on a transfer at (0,0), mode is captured. Changes to mode mid-frame are ignored.
- Even rows: pixel written to line_buf[col]. No output.
- Odd row, even col: pixel held in a single left register.
- Odd row, odd col: window = {line_buf[col-1], line_buf[col], left, in_data}.
  - Avg: sign-extend all four to DATA_W+2, sum, arithmetic shift right by 2 (floor toward -inf), truncate to DATA_W.
  - Max: signed maximum of the four.
- Result registered: out_valid=1 on the cycle after the window-completing transfer (latency 1).
- out_last=1 with the result of window (FM_H/2-1, FM_W/2-1).
- out_data and out_last hold stable while out_valid && !out_ready. out_valid clears on the out_valid && out_ready cycle unless a new result is loaded the same cycle.
- Simultaneous drain and new result: a drain and a new window-completing transfer in the same cycle loads the new result, so out_valid stays 1. Full throughput is 1 pixel/cycle with out_ready held high.
- frame_done pulses for exactly one cycle, coincident with the handshake of the out_last beat.
- Results per frame: (FM_W/2)*(FM_H/2), in raster order of pooled coordinates.
- Line buffer: FM_W x DATA_W register array, with one write per even-row pixel.

Test Plan:
- FM_W=FM_H=6, mode=0, pixels 0..35, out_ready=1 -> outputs 3,5,7,15,17,19,27,29,31. out_last only on 31. One frame_done pulse. in_ready never drops.
- Same stream, mode=1 -> outputs 7,9,11,19,21,23,31,33,35.
- Negative rounding on a 2x2 frame: pixels -1,-2,-3,-4. mode=0 -> out_data=-3 (sum -10 >>> 2). mode=1 -> -1. out_last=1 on that beat.
- Backpressure: out_ready=0 for 5 cycles when the first result appears -> out_data stays 3 and in_ready=0 for the whole stall, with no pixel lost. After release the remaining 8 outputs match the first case.
- Toggle mode to 1 at pixel 10 of an avg frame -> the whole frame stays avg. Mode applies from the next frame's (0,0).
- Assert rst at pixel 20 with out_valid=1 -> the next cycle shows out_valid=0. A fresh 0..35 frame then yields 3..31 exactly.
